// File: rtl/conv_pkg.sv
// conv_pkg: shared types and default geometry for the 3x3 window scheduler
package conv_pkg;
  localparam int DEF_PIX_W = 8;
  localparam int DEF_IMG_W = 64;
  localparam int DEF_IMG_H = 64;
  localparam int NUM_RES   = (DEF_IMG_W - 2) * (DEF_IMG_H - 2);
  typedef logic [2:0][2:0][DEF_PIX_W-1:0] win_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: two-line buffer giving column taps (r-2,c),(r-1,c),(r,c) for each accepted pixel
module conv_line_buf #(
  parameter int IMG_W = 64,
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [PIX_W-1:0]      pix,
  output logic [2:0][PIX_W-1:0] taps
);
  localparam int D  = IMG_W - 1;
  localparam int AW = D > 1 ? $clog2(D) : 1;
  logic [PIX_W-1:0] mem1 [D];
  logic [PIX_W-1:0] mem2 [D];
  logic [AW-1:0] ptr_q, ptr_d;
  logic [PIX_W-1:0] prev_q, prev_d, mid_q, mid_d;
  // a one-entry stage ahead of each D-deep memory makes the total delay exactly one line
  always_comb begin
    taps   = {pix, mem1[ptr_q], mem2[ptr_q]};
    ptr_d  = en ? (ptr_q == AW'(D - 1) ? '0 : ptr_q + AW'(1)) : ptr_q;
    prev_d = en ? pix : prev_q;
    mid_d  = en ? mem1[ptr_q] : mid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      prev_q <= '0;
      mid_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      prev_q <= prev_d;
      mid_q  <= mid_d;
    end
  end
  always_ff @(posedge clk) begin
    if (en) begin
      mem1[ptr_q] <= prev_q;
      mem2[ptr_q] <= mid_q;
    end
  end
endmodule

// File: rtl/conv_window_sched.sv
// conv_window_sched: frame sequencer forming 3x3 windows for the sharpening datapath, credit-tracked result FIFO
// Define CONV_CLAMP_EN to clamp results to the pixel range at FIFO push.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int PIX_W  = DEF_PIX_W,
  parameter int ACC_W  = 20,
  parameter int DP_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_idx,
  input  logic [PIX_W-1:0]             cfg_data,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic [PIX_W-1:0]             pix_data,
  output logic [2:0][2:0][PIX_W-1:0]   dp_img,
  output logic [2:0][2:0][PIX_W-1:0]   dp_fil,
  input  logic signed [ACC_W-1:0]      dp_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [ACC_W-1:0]      res_data
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int PW = FIFO_D > 1 ? $clog2(FIFO_D) : 1;
  localparam int NW = $clog2(FIFO_D + 1);
`ifdef CONV_CLAMP_EN
  localparam logic signed [ACC_W-1:0] MAX_PIX = ACC_W'((1 << PIX_W) - 1);
`endif
  state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0][2:0][PIX_W-1:0] img_q, img_d, fil_q, fil_d;
  logic [1:0][2:0][PIX_W-1:0] cols_q, cols_d;
  logic win_v_q, win_v_d;
  logic [DP_LAT-1:0] vld_q, vld_d;
  logic [NW-1:0] cred_q, cred_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic signed [ACC_W-1:0] fifo_q [FIFO_D];
  logic signed [ACC_W-1:0] push_data;
  logic [2:0][PIX_W-1:0] taps;
  logic issue_pos, accept, take, last_pix, push, pop;

  conv_line_buf #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .pix (pix_data),
    .taps(taps)
  );

  always_comb begin
    issue_pos = row_q >= RW'(2) && col_q >= CW'(2);
    pix_ready = state_q == RUN && (!issue_pos || cred_q != '0);
    accept    = pix_valid && pix_ready;
    take      = accept && issue_pos;
    last_pix  = row_q == RW'(IMG_H - 1) && col_q == CW'(IMG_W - 1);
    res_valid = cnt_q != '0;
    pop       = res_valid && res_ready;
    push      = vld_q[DP_LAT-1];
    busy      = state_q == RUN || state_q == DRAIN;
    done      = state_q == DONE;
    dp_img    = img_q;
    dp_fil    = fil_q;
    res_data  = res_valid ? fifo_q[rd_q] : '0;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = accept && last_pix ? DRAIN : RUN;
      DRAIN:   state_d = cred_q == NW'(FIFO_D) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
    col_d = col_q;
    row_d = row_q;
    if (state_q == IDLE && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      col_d = col_q == CW'(IMG_W - 1) ? '0 : col_q + CW'(1);
      row_d = col_q != CW'(IMG_W - 1) ? row_q : last_pix ? '0 : row_q + RW'(1);
    end
    cols_d = accept ? {taps, cols_q[1]} : cols_q;
    for (int i = 0; i < 3; i++) img_d[i] = take ? {taps[i], cols_q[1][i], cols_q[0][i]} : img_q[i];
    fil_d = fil_q;
    for (int k = 0; k < 9; k++)
      if (state_q == IDLE && cfg_we && cfg_idx == 4'(k)) fil_d[k/3][k%3] = cfg_data;
    win_v_d = take;
    vld_d   = DP_LAT'({vld_q, win_v_q});
`ifdef CONV_CLAMP_EN
    push_data = dp_out[ACC_W-1] ? '0 : dp_out > MAX_PIX ? MAX_PIX : dp_out;
`else
    push_data = dp_out;
`endif
    wr_d   = push ? (wr_q == PW'(FIFO_D - 1) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d   = pop ? (rd_q == PW'(FIFO_D - 1) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d  = cnt_q + NW'(push) - NW'(pop);
    cred_d = cred_q + NW'(pop) - NW'(take);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      cols_q  <= '0;
      img_q   <= '0;
      fil_q   <= '0;
      win_v_q <= 1'b0;
      vld_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      cred_q  <= NW'(FIFO_D);
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cols_q  <= cols_d;
      img_q   <= img_d;
      fil_q   <= fil_d;
      win_v_q <= win_v_d;
      vld_q   <= vld_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      cred_q  <= cred_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= push_data;
  end
endmodule

// File: tb/tb_conv_window_sched.sv
// tb_conv_window_sched: directed frames through conv_window_sched with a queued-expectation result monitor
module tb_conv_window_sched;
  import conv_pkg::*;
  localparam int W = 4, H = 4, PWD = 8, AW = 20, LAT = 1, FD = 4;
  logic clk = 1'b0;
  logic rst, start, busy, done, cfg_we;
  logic [3:0] cfg_idx;
  logic [PWD-1:0] cfg_data, pix_data;
  logic pix_valid, pix_ready, res_valid, res_ready;
  logic [2:0][2:0][PWD-1:0] dp_img, dp_fil;
  logic signed [AW-1:0] dp_out, res_data;
  int n_chk = 0, n_fail = 0, n_res = 0, r0;
  int cset [9];
  win_t coef_m;
  logic signed [AW-1:0] exp_q [$];

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(W), .IMG_H(H), .PIX_W(PWD), .ACC_W(AW), .DP_LAT(LAT), .FIFO_D(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .dp_img(dp_img), .dp_fil(dp_fil), .dp_out(dp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  function automatic int dp_sum(input logic [2:0][2:0][PWD-1:0] a, input logic [2:0][2:0][PWD-1:0] b);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) s += int'(a[i][j]) * int'($signed(b[i][j]));
    return s;
  endfunction

  // sharpening datapath stand-in: one-cycle registered multiply-accumulate
  always @(posedge clk) dp_out <= AW'(dp_sum(dp_img, dp_fil));

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      n_res++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL extra_result: got %0d, expected no result", res_data);
      end else check("result", res_data, exp_q.pop_front());
    end
  end

  function automatic logic [7:0] pix_val(input int m, input int r, input int c);
    return m < 256 ? 8'(m) : 8'(r * W + c);
  endfunction

  task automatic check_fil(input string name);
    for (int k = 0; k < 9; k++) check(name, dp_fil[k/3][k%3], coef_m[k/3][k%3]);
  endtask

  task automatic load_coef();
    for (int k = 0; k < 9; k++) begin
      cfg_we = 1'b1;
      cfg_idx = 4'(k);
      cfg_data = 8'(cset[k]);
      coef_m[k/3][k%3] = 8'(cset[k]);
      @(posedge clk); #1;
    end
    cfg_we = 1'b0;
    @(negedge clk);
    check_fil("fil_load");
  endtask

  task automatic expect4(input int a, input int b, input int c, input int d);
    exp_q.push_back(AW'(a));
    exp_q.push_back(AW'(b));
    exp_q.push_back(AW'(c));
    exp_q.push_back(AW'(d));
  endtask

  task automatic send_pix(input logic [7:0] d);
    int n = 0;
    pix_valid = 1'b1;
    pix_data = d;
    @(negedge clk);
    while (!pix_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("pix_ready_timeout", pix_ready, 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("done_timeout", done, 1);
    else begin
      check("drained_queue", exp_q.size(), 0);
      @(negedge clk);
      check("busy_after_done", busy, 0);
      check("done_width", done, 0);
    end
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int mode);
    start_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) send_pix(pix_val(mode, r, c));
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_data = '0;
    pix_valid = 1'b0; pix_data = '0; res_ready = 1'b1; coef_m = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_img_nonzero", dp_img != '0, 0);
    check_fil("rst_fil");
    // flat image, unit kernel
    cset = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_coef();
    expect4(9, 9, 9, 9);
    r0 = n_res;
    run_frame(1);
    check("t1_count", n_res - r0, 4);
    // binomial kernel on flat and ramp images
    cset = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    load_coef();
    expect4(80, 80, 80, 80);
    run_frame(5);
    expect4(80, 96, 144, 160);
    run_frame(256);
    // single-tap kernels pin window orientation; index 9 must be ignored
    cset = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    load_coef();
    cfg_we = 1'b1; cfg_idx = 4'd9; cfg_data = 8'd77;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    check_fil("idx9_ignored");
    expect4(0, 1, 4, 5);
    run_frame(256);
    cset = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    load_coef();
    expect4(10, 11, 14, 15);
    run_frame(256);
    // backpressure: all four results held in the FIFO, nothing lost on release
    cset = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_coef();
    @(posedge clk); #1 res_ready = 1'b0;
    expect4(45, 54, 81, 90);
    r0 = n_res;
    start_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) send_pix(pix_val(256, r, c));
    repeat (20) @(negedge clk);
    check("bp_held", n_res - r0, 0);
    check("bp_pix_ready", pix_ready, 0);
    check("bp_busy", busy, 1);
    check("bp_res_valid", res_valid, 1);
    @(posedge clk); #1 res_ready = 1'b1;
    wait_done();
    check("bp_total", n_res - r0, 4);
    // saturation and negative results
`ifdef CONV_CLAMP_EN
    expect4(255, 255, 255, 255);
`else
    expect4(2295, 2295, 2295, 2295);
`endif
    run_frame(255);
    cset = '{0, 0, 0, 0, 255, 0, 0, 0, 0};
    load_coef();
`ifdef CONV_CLAMP_EN
    expect4(0, 0, 0, 0);
`else
    expect4(-5, -6, -9, -10);
`endif
    run_frame(256);
    // reset mid-frame, then a clean frame
    cset = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_coef();
    start_frame();
    for (int k = 0; k < 6; k++) send_pix(8'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_pix_ready", pix_ready, 0);
    coef_m = '0;
    check_fil("mid_rst_fil");
    load_coef();
    expect4(9, 9, 9, 9);
    r0 = n_res;
    run_frame(1);
    check("t5_count", n_res - r0, 4);
    // config write and start while busy are ignored
    cset = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    load_coef();
    expect4(80, 80, 80, 80);
    r0 = n_res;
    start_frame();
    for (int k = 0; k < W * H; k++) begin
      send_pix(8'd5);
      if (k == 5) begin
        cfg_we = 1'b1; cfg_idx = 4'd4; cfg_data = 8'd99; start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; start = 1'b0;
        @(negedge clk);
        check_fil("busy_cfg_ignored");
        check("busy_start_ignored", busy, 1);
        @(posedge clk); #1;
      end
    end
    wait_done();
    check("t6_count", n_res - r0, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
